// File: rtl/bsg_manycore_lock_table_ctrl.sv
`timescale 1ns/1ps
// Multi-entry swap-lock table between endpoint and local memory: acquire/release = atomic read then store.
// Define BSG_MANYCORE_LOCK_CTRL_OWNER_CHECK_EN to let only the owning tile release a lock.
module bsg_manycore_lock_table_ctrl #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int lock_els_p     = 4,
  parameter int debug_p        = 0,
  localparam int mask_width_lp  = data_width_p >> 3,
  localparam int count_width_lp = $clog2(lock_els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      in_v_i,
  output logic                      in_yumi_o,
  input  logic [data_width_p-1:0]   in_data_i,
  input  logic [mask_width_lp-1:0]  in_mask_i,
  input  logic [addr_width_p-1:0]   in_addr_i,
  input  logic                      in_we_i,
  input  logic                      in_swap_aq_i,
  input  logic                      in_swap_rl_i,
  input  logic [x_cord_width_p-1:0] in_x_cord_i,
  input  logic [y_cord_width_p-1:0] in_y_cord_i,
  output logic                      comb_v_o,
  input  logic                      comb_yumi_i,
  output logic [data_width_p-1:0]   comb_data_o,
  output logic [mask_width_lp-1:0]  comb_mask_o,
  output logic [addr_width_p-1:0]   comb_addr_o,
  output logic                      comb_we_o,
  input  logic [data_width_p-1:0]   returning_data_i,
  input  logic                      returning_v_i,
  output logic [data_width_p-1:0]   comb_returning_data_o,
  output logic                      comb_returning_v_o,
  output logic [count_width_lp-1:0] lock_count_o
);
  localparam int idx_width_lp = (lock_els_p > 1) ? $clog2(lock_els_p) : 1;

  typedef enum logic {e_idle, e_store} state_e;
  state_e state_r, state_n;

  logic [lock_els_p-1:0]     valid_r;
  logic [addr_width_p-1:0]   addr_tab [lock_els_p];
  logic [x_cord_width_p-1:0] x_tab    [lock_els_p];
  logic [y_cord_width_p-1:0] y_tab    [lock_els_p];

  logic [data_width_p-1:0]  data_r, fail_data_r;
  logic [mask_width_lp-1:0] mask_r;
  logic [addr_width_p-1:0]  addr_r;
  logic fail_r, fail_n, suppress_r, suppress_n;
  logic latch, alloc, clear;

  logic hit, own, free_avail;
  logic [idx_width_lp-1:0] hit_idx, free_idx;
  logic [count_width_lp-1:0] count;

  // Result printing is left to the bench; the parameter stays for drop-in compatibility.
  logic unused_debug;
  assign unused_debug = (debug_p != 0);

  always_comb begin
    hit = 1'b0;
    own = 1'b0;
    hit_idx = '0;
    free_avail = 1'b0;
    free_idx = '0;
    for (int i = 0; i < lock_els_p; i++) begin
      if (valid_r[i] && (addr_tab[i] == in_addr_i)) begin
        hit = 1'b1;
        hit_idx = idx_width_lp'(i);
        own = (x_tab[i] == in_x_cord_i) && (y_tab[i] == in_y_cord_i);
      end
    end
    // Walk downwards so the lowest free index wins.
    for (int i = lock_els_p - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_avail = 1'b1;
        free_idx = idx_width_lp'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < lock_els_p; i++) count = count + count_width_lp'(valid_r[i]);
  end
  assign lock_count_o = count;

  logic is_normal, is_aq, is_rl, aq_ok, rl_ok, swap_ok;
  assign is_normal = ~in_swap_aq_i & ~in_swap_rl_i;
  assign is_aq     =  in_swap_aq_i & ~in_swap_rl_i;
  assign is_rl     = ~in_swap_aq_i &  in_swap_rl_i;
  assign aq_ok     = is_aq & ~hit & free_avail;
`ifdef BSG_MANYCORE_LOCK_CTRL_OWNER_CHECK_EN
  assign rl_ok     = is_rl & own;
`else
  assign rl_ok     = is_rl & hit;
  logic unused_own;
  assign unused_own = own;
`endif
  assign swap_ok   = aq_ok | rl_ok;

  always_comb begin
    state_n = state_r;
    in_yumi_o = 1'b0;
    comb_v_o = 1'b0;
    comb_data_o = in_data_i;
    comb_mask_o = in_mask_i;
    comb_addr_o = in_addr_i;
    comb_we_o = in_we_i;
    latch = 1'b0;
    alloc = 1'b0;
    clear = 1'b0;
    fail_n = 1'b0;
    suppress_n = 1'b0;
    case (state_r)
      e_idle: begin
        if (is_normal) begin
          comb_v_o = in_v_i;
          in_yumi_o = in_v_i & comb_yumi_i;
        end else if (swap_ok) begin
          comb_v_o = in_v_i;
          comb_we_o = 1'b0;
          in_yumi_o = in_v_i & comb_yumi_i;
          if (in_v_i & comb_yumi_i) begin
            latch = 1'b1;
            alloc = aq_ok;
            clear = rl_ok;
            state_n = e_store;
          end
        end else begin
          in_yumi_o = in_v_i;
          fail_n = in_v_i;
        end
      end
      default: begin
        comb_v_o = 1'b1;
        comb_we_o = 1'b1;
        comb_data_o = data_r;
        comb_mask_o = mask_r;
        comb_addr_o = addr_r;
        if (comb_yumi_i) begin
          state_n = e_idle;
          suppress_n = 1'b1;
        end
      end
    endcase
  end

  // Fail echoes and store-response suppression never overlap a live memory response.
  always_comb begin
    comb_returning_v_o = returning_v_i;
    comb_returning_data_o = returning_data_i;
    if (fail_r) begin
      comb_returning_v_o = 1'b1;
      comb_returning_data_o = fail_data_r;
    end else if (suppress_r) begin
      comb_returning_v_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      valid_r <= '0;
      fail_r <= 1'b0;
      suppress_r <= 1'b0;
    end else begin
      state_r <= state_n;
      fail_r <= fail_n;
      suppress_r <= suppress_n;
      if (alloc) valid_r[free_idx] <= 1'b1;
      if (clear) valid_r[hit_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (latch) begin
      data_r <= in_data_i;
      mask_r <= in_mask_i;
      addr_r <= in_addr_i;
    end
    if (fail_n) fail_data_r <= in_data_i;
    if (alloc) begin
      addr_tab[free_idx] <= in_addr_i;
      x_tab[free_idx] <= in_x_cord_i;
      y_tab[free_idx] <= in_y_cord_i;
    end
  end

endmodule

// File: tb/tb_bsg_manycore_lock_table_ctrl.sv
`timescale 1ns/1ps
// Bench for the lock table controller: vector table plus stall and reset-in-store sequences.
module tb_bsg_manycore_lock_table_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic        in_v_i, in_yumi_o, in_we_i, in_swap_aq_i, in_swap_rl_i;
  logic [31:0] in_data_i, in_addr_i;
  logic [3:0]  in_mask_i, in_x_cord_i, in_y_cord_i;
  logic        comb_v_o, comb_yumi_i, comb_we_o;
  logic [31:0] comb_data_o, comb_addr_o;
  logic [3:0]  comb_mask_o;
  logic [31:0] returning_data_i, comb_returning_data_o;
  logic        returning_v_i, comb_returning_v_o;
  logic [2:0]  lock_count_o;

  bsg_manycore_lock_table_ctrl #(
    .data_width_p(32), .addr_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
    .lock_els_p(4), .debug_p(0)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_yumi_o(in_yumi_o),
    .in_data_i(in_data_i), .in_mask_i(in_mask_i), .in_addr_i(in_addr_i), .in_we_i(in_we_i),
    .in_swap_aq_i(in_swap_aq_i), .in_swap_rl_i(in_swap_rl_i),
    .in_x_cord_i(in_x_cord_i), .in_y_cord_i(in_y_cord_i),
    .comb_v_o(comb_v_o), .comb_yumi_i(comb_yumi_i),
    .comb_data_o(comb_data_o), .comb_mask_o(comb_mask_o), .comb_addr_o(comb_addr_o), .comb_we_o(comb_we_o),
    .returning_data_i(returning_data_i), .returning_v_i(returning_v_i),
    .comb_returning_data_o(comb_returning_data_o), .comb_returning_v_o(comb_returning_v_o),
    .lock_count_o(lock_count_o)
  );

  typedef struct {
    logic        aq;
    logic        rl;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        ok;
    logic [2:0]  cnt;
  } vec_t;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q   [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic vec_t mk(input logic aq, input logic rl, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] x, input logic [3:0] y,
                              input logic ok, input logic [2:0] cnt);
    vec_t v;
    v.aq = aq; v.rl = rl; v.addr = addr; v.data = data;
    v.x = x; v.y = y; v.ok = ok; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory: accepts when comb_v_o & comb_yumi_i, answers every accept one cycle later with pre-write data.
  initial begin
    logic acc, w;
    logic [7:0] a;
    logic [31:0] d;
    logic [3:0] m;
    returning_v_i = 1'b0;
    returning_data_i = '0;
    forever begin
      @(negedge clk);
      acc = comb_v_o & comb_yumi_i;
      a = comb_addr_o[7:0];
      w = comb_we_o;
      d = comb_data_o;
      m = comb_mask_o;
      @(posedge clk);
      #1;
      returning_v_i = acc;
      if (acc) begin
        returning_data_i = mem[a];
        if (w) for (int b = 0; b < 4; b++) if (m[b]) mem[a][8*b +: 8] = d[8*b +: 8];
      end
    end
  end

  // Response scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (comb_returning_v_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_resp: got response 0x%08h, expected none", comb_returning_data_o);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", comb_returning_data_o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input vec_t v, input logic [31:0] exp_resp, input logic hold);
    logic got;
    got = 1'b0;
    in_swap_aq_i = v.aq;
    in_swap_rl_i = v.rl;
    in_addr_i = v.addr;
    in_data_i = v.data;
    in_x_cord_i = v.x;
    in_y_cord_i = v.y;
    in_mask_i = 4'hF;
    in_we_i = 1'b0;
    in_v_i = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_yumi_o) begin
        got = 1'b1;
        check("mem_req_issued", 32'(comb_v_o), 32'(v.ok));
        if (v.ok) check("read_addr", comb_addr_o, v.addr);
        exp_q.push_back(exp_resp);
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted, expected acceptance", v.addr);
    end
    @(posedge clk);
    #1;
    in_v_i = 1'b0;
    in_swap_aq_i = 1'b0;
    in_swap_rl_i = 1'b0;
    if (hold) comb_yumi_i = 1'b0;
    if (got) begin
      @(negedge clk);
      check("resp_latency", 32'(comb_returning_v_o), 32'd1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input logic hold);
    logic [31:0] exp_resp;
    exp_resp = v.ok ? ref_mem[v.addr[7:0]] : v.data;
    do_req(v, exp_resp, hold);
    if (!hold) begin
      repeat (3) @(posedge clk);
      #1;
      check("lock_count", 32'(lock_count_o), 32'(v.cnt));
      if (v.ok && (v.aq || v.rl)) begin
        check("store_data", mem[v.addr[7:0]], v.data);
        ref_mem[v.addr[7:0]] = v.data;
      end
    end
  endtask

  vec_t vecs [13];

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + 32'(i);
    mem[8'h10] = 32'hAA;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    vecs[0]  = mk(1'b1, 1'b0, 32'h10, 32'h1,  4'd1, 4'd2, 1'b1, 3'd1);
    vecs[1]  = mk(1'b1, 1'b0, 32'h10, 32'h5,  4'd3, 4'd3, 1'b0, 3'd1);
    vecs[2]  = mk(1'b1, 1'b0, 32'h20, 32'h2,  4'd1, 4'd1, 1'b1, 3'd2);
    vecs[3]  = mk(1'b1, 1'b0, 32'h30, 32'h3,  4'd2, 4'd1, 1'b1, 3'd3);
    vecs[4]  = mk(1'b1, 1'b0, 32'h40, 32'h4,  4'd2, 4'd2, 1'b1, 3'd4);
    vecs[5]  = mk(1'b1, 1'b0, 32'h50, 32'h55, 4'd3, 4'd1, 1'b0, 3'd4);
    vecs[6]  = mk(1'b0, 1'b1, 32'h30, 32'h33, 4'd2, 4'd1, 1'b1, 3'd3);
    vecs[7]  = mk(1'b1, 1'b0, 32'h50, 32'h56, 4'd3, 4'd1, 1'b1, 3'd4);
`ifdef BSG_MANYCORE_LOCK_CTRL_OWNER_CHECK_EN
    vecs[8]  = mk(1'b0, 1'b1, 32'h10, 32'h7,  4'd3, 4'd3, 1'b0, 3'd4);
    vecs[9]  = mk(1'b0, 1'b1, 32'h10, 32'h8,  4'd1, 4'd2, 1'b1, 3'd3);
`else
    vecs[8]  = mk(1'b0, 1'b1, 32'h10, 32'h7,  4'd3, 4'd3, 1'b1, 3'd3);
    vecs[9]  = mk(1'b0, 1'b1, 32'h10, 32'h8,  4'd1, 4'd2, 1'b0, 3'd3);
`endif
    vecs[10] = mk(1'b1, 1'b1, 32'h20, 32'h9,  4'd1, 4'd1, 1'b0, 3'd3);
    vecs[11] = mk(1'b0, 1'b1, 32'h60, 32'h66, 4'd1, 4'd1, 1'b0, 3'd3);
    vecs[12] = mk(1'b0, 1'b0, 32'h20, 32'h0,  4'd1, 4'd1, 1'b1, 3'd3);

    reset_i = 1'b1;
    in_v_i = 1'b0; in_we_i = 1'b0; in_swap_aq_i = 1'b0; in_swap_rl_i = 1'b0;
    in_data_i = '0; in_addr_i = '0; in_mask_i = 4'hF; in_x_cord_i = '0; in_y_cord_i = '0;
    comb_yumi_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("reset_count", 32'(lock_count_o), 32'd0);
    check("reset_comb_v", 32'(comb_v_o), 32'd0);
    check("reset_yumi", 32'(in_yumi_o), 32'd0);
    check("reset_ret_v", 32'(comb_returning_v_o), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], 1'b0);

    // Store held off for three cycles while a normal request waits behind it.
    run_vec(mk(1'b1, 1'b0, 32'h80, 32'hCAFE, 4'd0, 4'd1, 1'b1, 3'd4), 1'b1);
    in_swap_aq_i = 1'b0; in_swap_rl_i = 1'b0;
    in_addr_i = 32'h20; in_data_i = '0; in_v_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_store_v", 32'(comb_v_o), 32'd1);
      check("stall_store_we", 32'(comb_we_o), 32'd1);
      check("stall_store_addr", comb_addr_o, 32'h80);
      check("stall_store_data", comb_data_o, 32'hCAFE);
      check("stall_no_yumi", 32'(in_yumi_o), 32'd0);
      @(posedge clk);
      #1;
    end
    comb_yumi_i = 1'b1;
    run_vec(mk(1'b0, 1'b0, 32'h20, 32'h0, 4'd1, 4'd1, 1'b1, 3'd4), 1'b0);
    check("stall_store_mem", mem[8'h80], 32'hCAFE);
    ref_mem[8'h80] = 32'hCAFE;

    // Reset while a store is pending: store abandoned, table emptied.
    run_vec(mk(1'b0, 1'b1, 32'h80, 32'hBEEF, 4'd0, 4'd1, 1'b1, 3'd3), 1'b0);
    run_vec(mk(1'b1, 1'b0, 32'h90, 32'h99, 4'd0, 4'd1, 1'b1, 3'd4), 1'b1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    comb_yumi_i = 1'b1;
    @(negedge clk);
    check("rst_store_count", 32'(lock_count_o), 32'd0);
    check("rst_store_idle", 32'(comb_v_o), 32'd0);
    check("rst_store_ret_v", 32'(comb_returning_v_o), 32'd0);
    @(posedge clk);
    #1;
    check("rst_store_abandoned", mem[8'h90], 32'h1090);
    run_vec(mk(1'b1, 1'b0, 32'h20, 32'h21, 4'd1, 4'd1, 1'b1, 3'd1), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
